ifetch_queue: RTL
=================

# ifetch_queue

Instruction fetch front-end for the pipelined RV32I variant. It owns the fetch PC and issues word requests to instruction memory over a valid/ready request channel with in-order, variable-latency responses. Returned instructions are buffered with their PCs in a DEPTH-entry queue and presented to decode over a valid/ready channel. Execute-stage redirects (branches/jumps) flush the queue, restart fetch at the target and discard stale in-flight responses.

## Interface
- RESET_PC, 32'h0000_0000, fetch PC loaded by reset; bits [1:0] must be 0
- DEPTH, 4, queue entries / max outstanding requests; power of 2, >= 2
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  redirect target; bits [1:0] ignored (treated as 00)
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  32  fetch word address
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  response valid (in order, at most one per cycle)
- imem_rsp_data  in  32  instruction word
- inst_valid  out  1  head entry filled and available to decode
- inst_data  out  32  head instruction
- inst_pc  out  32  PC of head instruction
- inst_ready  in  1  decode accepts head

## Operation
- State: fetch_pc; DEPTH-entry queue of {pc, data, filled}; alloc/fill/head pointers; alloc_count (0..DEPTH); drop_count (0..DEPTH).
- Issue: imem_req_valid = (alloc_count + drop_count < DEPTH) and rst_n deasserted; imem_req_addr = fetch_pc. Driven from registered state only (no combinational path from redirect_valid, imem_rsp_*, inst_ready).
- Request accepted (valid & ready, no redirect): allocate tail entry with pc = fetch_pc, filled = 0; fetch_pc += 4, wrapping 0xFFFF_FFFC -> 0x0000_0000.
- Response: if drop_count > 0, discard and decrement drop_count; else write data into fill-pointer entry, set filled, advance fill pointer.
- Pop: inst_valid = head entry filled; inst_valid & inst_ready frees head. Allocation, fill and pop may all occur in one cycle.
- Redirect (takes effect at the edge): queue emptied (all pointers/alloc_count to 0); fetch_pc <= {redirect_pc[31:2], 2'b00}; drop_count <= drop_count + (allocated-unfilled entries) + (request accepted this cycle) - (response arriving this cycle, which is itself discarded). Pop in the redirect cycle is legal and has no further effect.
- Reset: async clear of all state; fetch_pc = RESET_PC; imem_req_valid = 0 while rst_n low; inst_valid = 0, inst_data = 0, inst_pc = 0. Instruction memory shares rst_n; no pre-reset response arrives after reset.
- Protocol errors (response with no outstanding request) are not handled.

## Timing
- Request accepted in cycle N; response in cycle N+k (k >= 1); inst_valid high in N+k+1 (registered fill).
- With k = 1, DEPTH >= 2 sustains one instruction per cycle; in general DEPTH >= k+1.
- imem_req_addr stable while imem_req_valid & !imem_req_ready, except across a redirect edge.
- First request: cycle after rst_n rises, address RESET_PC.
- After a redirect in cycle R: inst_valid = 0 in R+1; first new-target request presented in R+1 if credit permits; redirect in consecutive cycles: last one wins, drop_count accumulates.
- Queue full (alloc_count = DEPTH): imem_req_valid = 0 until a pop.

## Test plan
- Reset release, imem_req_ready = 1, k = 1, inst_ready = 1 -> requests 0x0,0x4,0x8,... each cycle; inst_pc/inst_data stream 0x0,0x4,... one per cycle from third cycle.
- inst_ready = 0 with DEPTH = 4 -> exactly 4 requests accepted, then imem_req_valid = 0; raising inst_ready resumes with addr 0x10.
- k = 3 with 2 outstanding, redirect to 0x0000_0103 -> both old responses discarded, next inst_pc = 0x0000_0100, no 0x0/0x4 instructions delivered.
- Redirect in same cycle as a response and an accepted request -> that response and request's reply both dropped; next delivered instruction from redirect target.
- RESET_PC = 0xFFFF_FFF8 -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 in order.
- rst_n low mid-stream with full queue -> immediately inst_valid = 0, imem_req_valid = 0; after release first request at RESET_PC.

Source files
------------

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - Instruction fetch front-end: PC owner, request issue and in-order fetch queue.
// Redirects flush the queue and count still-outstanding responses so they are dropped on return.
module ifetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [31:0]      fetch_pc;
  logic             run;
  logic [31:0]      q_pc   [DEPTH];
  logic [31:0]      q_data [DEPTH];
  logic [DEPTH-1:0] q_filled;
  logic [AW-1:0]    head_ptr, fill_ptr, alloc_ptr;
  logic [CW-1:0]    alloc_count, pend_count, drop_count;
  logic [CW:0]      credit_used;
  logic             req_fire, rsp_keep, pop;
  logic             redirect_pc_unused;

  assign redirect_pc_unused = ^redirect_pc[1:0];

  // Credit covers live entries plus responses still owed to flushed requests.
  assign credit_used    = {1'b0, alloc_count} + {1'b0, drop_count};
  assign imem_req_valid = run && (credit_used < DEPTH_C);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_keep       = imem_rsp_valid && (drop_count == '0);

  assign inst_valid = q_filled[head_ptr];
  assign inst_data  = q_data[head_ptr];
  assign inst_pc    = q_pc[head_ptr];
  assign pop        = inst_valid && inst_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run         <= 1'b0;
      fetch_pc    <= RESET_PC;
      head_ptr    <= '0;
      fill_ptr    <= '0;
      alloc_ptr   <= '0;
      alloc_count <= '0;
      pend_count  <= '0;
      drop_count  <= '0;
      q_filled    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_pc[i]   <= '0;
        q_data[i] <= '0;
      end
    end else begin
      run <= 1'b1;
      if (redirect_valid) begin
        fetch_pc    <= {redirect_pc[31:2], 2'b00};
        head_ptr    <= '0;
        fill_ptr    <= '0;
        alloc_ptr   <= '0;
        alloc_count <= '0;
        pend_count  <= '0;
        q_filled    <= '0;
        // A response arriving now is dropped here, so it is not owed later.
        drop_count  <= drop_count + pend_count + CW'(req_fire) - CW'(imem_rsp_valid);
      end else begin
        if (req_fire) begin
          q_pc[alloc_ptr]     <= fetch_pc;
          q_filled[alloc_ptr] <= 1'b0;
          alloc_ptr           <= alloc_ptr + AW'(1);
          fetch_pc            <= fetch_pc + 32'd4;
        end
        if (imem_rsp_valid) begin
          if (drop_count != '0) begin
            drop_count <= drop_count - CW'(1);
          end else begin
            q_data[fill_ptr]   <= imem_rsp_data;
            q_filled[fill_ptr] <= 1'b1;
            fill_ptr           <= fill_ptr + AW'(1);
          end
        end
        if (pop) begin
          q_filled[head_ptr] <= 1'b0;
          head_ptr           <= head_ptr + AW'(1);
        end
        alloc_count <= alloc_count + CW'(req_fire) - CW'(pop);
        pend_count  <= pend_count + CW'(req_fire) - CW'(rsp_keep);
      end
    end
  end
endmodule
